// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache: combinational hit path, and a
// stall-and-refill path that fetches one 32-byte line from backing memory on a miss.
module icache_ctrl #(
    parameter int INDEX_BITS = 5,
    parameter int LINE_BITS  = 256,
    parameter int TAG_BITS   = 32 - 5 - INDEX_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          p_addr_i,
    input  logic                 p_req_i,
    output logic [31:0]          p_inst_o,
    output logic                 p_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic                 mem_enable_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
);
    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [LINES-1:0]       r_valid;
    logic [TAG_BITS-1:0]    r_tag  [LINES];
    logic [LINE_BITS-1:0]   r_data [LINES];
    logic [26:0]            r_line_addr;
    logic [31:0]            r_hit_cnt;
    logic [31:0]            r_miss_cnt;

    logic [TAG_BITS-1:0]    w_tag;
    logic [INDEX_BITS-1:0]  w_index;
    logic [2:0]             w_word;
    logic [TAG_BITS-1:0]    w_fill_tag;
    logic [INDEX_BITS-1:0]  w_fill_index;
    logic                   w_hit;
    logic                   w_miss;
    logic                   w_fill;
    logic                   w_unused;

    assign w_tag        = p_addr_i[31:5+INDEX_BITS];
    assign w_index      = p_addr_i[4+INDEX_BITS:5];
    assign w_word       = p_addr_i[4:2];
    assign w_fill_tag   = r_line_addr[26:INDEX_BITS];
    assign w_fill_index = r_line_addr[INDEX_BITS-1:0];
    assign w_unused     = ^p_addr_i[1:0];

    // Lookup is only meaningful in IDLE; during REFILL the fetch side is stalled.
    assign w_hit  = (r_state == IDLE) && p_req_i && r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_miss = (r_state == IDLE) && p_req_i && !w_hit;
    assign w_fill = (r_state == REFILL) && mem_ack_i;

    // Memory handshake: mem_enable_o is the request and stays high with a stable
    // mem_addr_o until the one-cycle mem_ack_i strobe, which carries the line.
    always_comb begin
        w_state_next = r_state;
        p_stall_o    = 1'b0;
        p_inst_o     = 32'h0;
        mem_enable_o = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    p_inst_o = r_data[w_index][{w_word, 5'b0} +: 32];
                end else if (p_req_i) begin
                    p_stall_o    = 1'b1;
                    w_state_next = REFILL;
                end
            end
            REFILL: begin
                p_stall_o    = 1'b1;
                mem_enable_o = 1'b1;
                if (mem_ack_i) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign mem_addr_o = {r_line_addr, 5'b0};
    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_valid     <= '0;
            r_line_addr <= '0;
            r_hit_cnt   <= 32'h0;
            r_miss_cnt  <= 32'h0;
        end else begin
            r_state <= w_state_next;
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss) begin
                r_miss_cnt  <= r_miss_cnt + 32'd1;
                r_line_addr <= p_addr_i[31:5];
            end
            if (w_fill) begin
                r_valid[w_fill_index] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; the valid bits gate every use.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_fill) begin
            r_tag[w_fill_index]  <= w_fill_tag;
            r_data[w_fill_index] <= mem_data_i;
        end
    end
endmodule
